collision_scorer: RTL and testbench



---
 rtl/collision_scorer_if.sv | 24 ++
 rtl/collision_scorer.sv | 190 +++++++++++++++++++
 tb/tb_collision_scorer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/collision_scorer_if.sv
// Signal bundle between the ball/wall movers, VGA timing and collision_scorer.
// The master side (movers, VGA counters, button) drives the coordinates and the
// flap level; the slave side (the scorer) returns run and the status bus.
interface collision_scorer_if;
    logic        flap;
    logic [9:0]  v_counter;
    logic [9:0]  ballX;
    logic [9:0]  ballY;
    logic [9:0]  wallX;
    logic [9:0]  wallYU;
    logic [9:0]  wallYL;
    logic        run;
    logic [15:0] status;

    modport master (
        output flap, v_counter, ballX, ballY, wallX, wallYU, wallYL,
        input  run, status
    );

    modport slave (
        input  flap, v_counter, ballX, ballY, wallX, wallYU, wallYL,
        output run, status
    );
endinterface

// File: rtl/collision_scorer.sv
// collision_scorer: per-frame game logic for the flappy game.
// Once per frame (end of visible area) it checks ball/wall/ground collisions,
// counts walls passed as a saturating two-digit BCD score and runs the
// READY/RUN/HIT/OVER game state machine. status[15:8] carries the score,
// status[2] the hit latch and status[1:0] the state.
// Optional feature: define FLAPPY_HISCORE_EN to keep a BCD high score that is
// shown on status[7:0] while in READY or OVER.
module collision_scorer #(
    parameter int unsigned BALL_SIZE   = 10,
    parameter int unsigned WALL_W      = 40,
    parameter int unsigned GROUND_Y    = 470,
    parameter int unsigned FRAME_ROW   = 480,
    parameter int unsigned DEAD_FRAMES = 60
) (
    input logic              clk,
    input logic              rst,
    collision_scorer_if.slave bus
);

    typedef enum logic [1:0] {
        READY = 2'b00,
        RUN   = 2'b01,
        HIT   = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  score_inc;
    logic [7:0]  dead_q, dead_d;
    logic        hit_q, hit_d;
    logic        pend_q, pend_d;
    logic        flap_q;
    logic [9:0]  v_q;
    logic [10:0] prev_right_q;
    logic        run_q;

    logic        tick;
    logic        flap_rise;
    logic        flap_seen;
    logic [10:0] ball_left;
    logic [10:0] ball_right;
    logic [10:0] ball_top;
    logic [10:0] ball_bottom;
    logic [10:0] wall_left;
    logic [10:0] wall_right;
    logic        x_overlap;
    logic        y_hit;
    logic        collision;
    logic        pass;

`ifdef FLAPPY_HISCORE_EN
    logic [7:0]  hiscore_q, hiscore_d;
`endif

    // Frame tick and button edge detection
    assign tick      = (bus.v_counter == 10'(FRAME_ROW)) && (v_q != 10'(FRAME_ROW));
    assign flap_rise = bus.flap & ~flap_q;
    // A rise arriving on the tick cycle itself is not lost
    assign flap_seen = pend_q | flap_rise;

    // Geometry in 11 bits so edge sums never wrap
    assign ball_left   = {1'b0, bus.ballX};
    assign ball_right  = {1'b0, bus.ballX} + 11'(BALL_SIZE - 1);
    assign ball_top    = {1'b0, bus.ballY};
    assign ball_bottom = {1'b0, bus.ballY} + 11'(BALL_SIZE - 1);
    assign wall_left   = {1'b0, bus.wallX};
    assign wall_right  = {1'b0, bus.wallX} + 11'(WALL_W - 1);

    assign x_overlap = (ball_right >= wall_left) && (ball_left <= wall_right);
    assign y_hit     = (ball_top < {1'b0, bus.wallYU}) || (ball_bottom >= {1'b0, bus.wallYL});
    assign collision = (x_overlap && y_hit) || (ball_bottom >= 11'(GROUND_Y));

    // A respawn moves the wall right, so cur < ballX <= prev already excludes it
    assign pass = (state_q == RUN) && !collision &&
                  (prev_right_q >= ball_left) && (wall_right < ball_left);

    // Saturating two-digit BCD increment of the score
    always_comb begin
        score_inc = score_q;
        if (score_q != 8'h99) begin
            if (score_q[3:0] == 4'd9) begin
                score_inc[7:4] = score_q[7:4] + 4'd1;
                score_inc[3:0] = 4'd0;
            end else begin
                score_inc[3:0] = score_q[3:0] + 4'd1;
            end
        end
    end

    // Game state machine next-state and per-tick bookkeeping
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        dead_d  = dead_q;
        hit_d   = hit_q;
        pend_d  = pend_q;
`ifdef FLAPPY_HISCORE_EN
        hiscore_d = hiscore_q;
`endif
        if (tick) begin
            pend_d = 1'b0;
            case (state_q)
                READY: begin
                    if (flap_seen) begin
                        state_d = RUN;
                        score_d = '0;
                    end
                end
                RUN: begin
                    if (collision) begin
                        state_d = HIT;
                        hit_d   = 1'b1;
                        dead_d  = '0;
`ifdef FLAPPY_HISCORE_EN
                        if (score_q > hiscore_q) begin
                            hiscore_d = score_q;
                        end
`endif
                    end else if (pass) begin
                        score_d = score_inc;
                    end
                end
                HIT: begin
                    if (dead_q == 8'(DEAD_FRAMES - 1)) begin
                        state_d = OVER;
                    end else begin
                        dead_d = dead_q + 8'd1;
                    end
                end
                OVER: begin
                    if (flap_seen) begin
                        state_d = READY;
                        hit_d   = 1'b0;
                    end
                end
                default: state_d = READY;
            endcase
        end else if (flap_rise) begin
            pend_d = 1'b1;
        end
    end

    // State, score and edge-detect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= READY;
            score_q      <= '0;
            dead_q       <= '0;
            hit_q        <= 1'b0;
            pend_q       <= 1'b0;
            flap_q       <= 1'b0;
            v_q          <= '0;
            prev_right_q <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            dead_q  <= dead_d;
            hit_q   <= hit_d;
            pend_q  <= pend_d;
            flap_q  <= bus.flap;
            v_q     <= bus.v_counter;
            run_q   <= (state_d == RUN);
            if (tick) begin
                prev_right_q <= wall_right;
            end
        end
    end

`ifdef FLAPPY_HISCORE_EN
    // High-score register
    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign bus.status[15:8] = score_q;
    assign bus.status[7:0]  = ((state_q == READY) || (state_q == OVER)) ?
                              hiscore_q : {5'b0, hit_q, state_q};
`else
    assign bus.status = {score_q, 5'b0, hit_q, state_q};
`endif

    assign bus.run = run_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Self-checking bench for collision_scorer: directed steps followed by a
// randomized run, all compared against an integer-level game model.
module tb_collision_scorer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    collision_scorer_if bus();

    collision_scorer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference game model: plain integers (state 0..3, score 0..99)
    int m_state, m_score, m_dead, m_hit, m_pend, m_prev;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_status();
        return ((m_score / 10) * 16 + (m_score % 10)) * 256 + m_hit * 4 + m_state;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_dead = 0; m_hit = 0; m_pend = 0; m_prev = 0;
    endtask

    task automatic model_tick();
        int bx, by, wx, wr, bb;
        bit xo, yh, col, pas;
        bx = int'(bus.ballX);
        by = int'(bus.ballY);
        wx = int'(bus.wallX);
        wr = wx + 39;
        bb = by + 9;
        xo  = (bx + 9 >= wx) && (bx <= wr);
        yh  = (by < int'(bus.wallYU)) || (bb >= int'(bus.wallYL));
        col = (xo && yh) || (bb >= 470);
        pas = (m_state == 1) && !col && (m_prev >= bx) && (wr < bx);
        case (m_state)
            0: if (m_pend != 0) begin m_state = 1; m_score = 0; end
            1: begin
                if (col) begin
                    m_state = 2; m_hit = 1; m_dead = 0;
                end else if (pas && m_score < 99) begin
                    m_score++;
                end
            end
            2: begin
                m_dead++;
                if (m_dead == 60) m_state = 3;
            end
            default: if (m_pend != 0) begin m_state = 0; m_hit = 0; end
        endcase
        m_pend = 0;
        m_prev = wr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_pos(input int bx, input int by, input int wx, input int wyu, input int wyl);
        bus.ballX  = 10'(bx);
        bus.ballY  = 10'(by);
        bus.wallX  = 10'(wx);
        bus.wallYU = 10'(wyu);
        bus.wallYL = 10'(wyl);
    endtask

    task automatic flap_pulse();
        @(negedge clk);
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
        m_pend = 1;
    endtask

    // One frame end: v_counter hits 480 for one cycle, then outputs checked
    task automatic frame();
        @(negedge clk);
        bus.v_counter = 10'd480;
        @(negedge clk);
        bus.v_counter = 10'd0;
        model_tick();
        chk("status", bus.status, 16'(exp_status()));
        chk("run", 16'(bus.run), 16'(m_state == 1));
    endtask

    // Wall right edge 101 then 99 across ballX=100 with the ball in the gap
    task automatic do_pass();
        set_pos(100, 200, 62, 150, 300);
        frame();
        set_pos(100, 200, 60, 150, 300);
        frame();
    endtask

    initial begin
        int wx, wyu, by, step;
        rst           = 1'b1;
        bus.flap      = 1'b0;
        bus.v_counter = 10'd0;
        set_pos(100, 200, 400, 150, 300);
        model_reset();

        do_reset();
        chk("reset_status", bus.status, 16'h0000);
        chk("reset_run", 16'(bus.run), 16'h0000);

        // Start the game
        flap_pulse();
        set_pos(100, 200, 400, 150, 300);
        frame();
        chk("start_state", 16'(bus.status[1:0]), 16'h0001);
        chk("start_run", 16'(bus.run), 16'h0001);

        // First pass
        do_pass();
        chk("score_01", 16'(bus.status[15:8]), 16'h0001);

        // Ones-digit carry
        for (int i = 0; i < 8; i++) do_pass();
        chk("score_09", 16'(bus.status[15:8]), 16'h0009);
        do_pass();
        chk("score_10", 16'(bus.status[15:8]), 16'h0010);

        // Saturation at 99
        for (int i = 0; i < 89; i++) do_pass();
        chk("score_99", 16'(bus.status[15:8]), 16'h0099);
        do_pass();
        chk("score_sat", 16'(bus.status[15:8]), 16'h0099);

        // Upper-wall collision
        set_pos(100, 50, 95, 80, 300);
        frame();
        chk("hit_state", 16'(bus.status[2:0]), 16'h0006);
        chk("hit_run", 16'(bus.run), 16'h0000);
        set_pos(100, 200, 400, 150, 300);
        for (int i = 0; i < 59; i++) frame();
        chk("hit_hold", 16'(bus.status[1:0]), 16'h0002);
        frame();
        chk("over_state", 16'(bus.status[1:0]), 16'h0003);

        // OVER -> READY clears the hit latch, then restart
        flap_pulse();
        frame();
        chk("ready_again", 16'(bus.status[2:0]), 16'h0000);
        flap_pulse();
        frame();
        chk("restart_score", 16'(bus.status[15:8]), 16'h0000);

        // Ground hit on the same tick as a pass: collision wins
        set_pos(100, 200, 62, 150, 300);
        frame();
        set_pos(100, 465, 60, 150, 300);
        frame();
        chk("ground_state", 16'(bus.status[1:0]), 16'h0002);
        chk("ground_score", 16'(bus.status[15:8]), 16'h0000);

        // Reset in the middle of HIT
        set_pos(100, 200, 400, 150, 300);
        frame();
        do_reset();
        chk("midhit_reset", bus.status, 16'h0000);
        chk("midhit_run", 16'(bus.run), 16'h0000);

        // Randomized play: leftward-moving wall, ball mostly in the gap
        wx = 600;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) flap_pulse();
            step = int'($urandom_range(5, 25));
            if (wx < step + 1) wx = 600;
            else wx = wx - step;
            wyu = int'($urandom_range(100, 250));
            if ($urandom_range(0, 7) == 0) by = int'($urandom_range(0, 479));
            else by = wyu + int'($urandom_range(0, 110));
            set_pos(100, by, wx, wyu, wyu + 120);
            frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
